// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : State encoding, opcode fields and control-word type for the
//            multicycle CPU control unit.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_FETCH2 = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_JUMP   = 4'd6,
    S_EXEC   = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_TR  = 4'd9,
    S_MOV    = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEMREF = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_MOV    = 3'd2,
    CLS_ADDI   = 3'd3,
    CLS_LDI    = 3'd4,
    CLS_HALT   = 3'd5
  } instr_class_t;

  // Opcode fields: OP_MEMREF matches ir[7], OP_ALU matches ir[7:6], rest ir[7:4]
  localparam logic       OP_MEMREF = 1'b0;
  localparam logic [1:0] OP_ALU    = 2'b10;
  localparam logic [3:0] OP_MOV    = 4'b1100;
  localparam logic [3:0] OP_ADDI   = 4'b1101;
  localparam logic [3:0] OP_LDI    = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [1:0] MEM_LOAD   = 2'b00;
  localparam logic [1:0] MEM_STORE  = 2'b01;
  localparam logic [1:0] MEM_JUMP   = 2'b10;
  localparam logic [1:0] MEM_BRANCH = 2'b11;

  typedef struct packed {
    logic ld_PC;
    logic ld_IR;
    logic ld_DI;
    logic ld_TR;
    logic ld_ALU;
    logic ld_CZN;
    logic write_reg_en;
    logic mem_write;
    logic sel_PC_src_JUMP;
    logic sel_MEM_src_TR;
    logic sel_MEM_src_PC;
    logic sel_IR_3_2;
    logic sel_IR_4_3;
    logic sel_RF_write_src_TR_12_5;
    logic sel_RF_write_src_reg1;
    logic sel_RF_write_src_ALU;
    logic sel_ALU_src_reg1;
    logic sel_ALU_src_TR;
    logic sel_CZN_src_RF;
    logic sel_CZN_src_ALU;
    logic halted;
  } ctrl_t;

  // Idle control word: nothing loads, every select pair at its default leg
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c                      = '0;
    c.sel_MEM_src_PC       = 1'b1;
    c.sel_IR_3_2           = 1'b1;
    c.sel_RF_write_src_ALU = 1'b1;
    c.sel_ALU_src_reg1     = 1'b1;
    c.sel_CZN_src_ALU      = 1'b1;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_if
// Brief    : Control interface between control_unit (master) and the datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface control_unit_if;
  logic [7:0] ir;
  logic       cond_met;
  logic       ld_PC;
  logic       ld_IR;
  logic       ld_DI;
  logic       ld_TR;
  logic       ld_ALU;
  logic       ld_CZN;
  logic       write_reg_en;
  logic       mem_write;
  logic       sel_PC_src_JUMP;
  logic       sel_MEM_src_TR;
  logic       sel_MEM_src_PC;
  logic       sel_IR_3_2;
  logic       sel_IR_4_3;
  logic       sel_RF_write_src_TR_12_5;
  logic       sel_RF_write_src_reg1;
  logic       sel_RF_write_src_ALU;
  logic       sel_ALU_src_reg1;
  logic       sel_ALU_src_TR;
  logic       sel_CZN_src_RF;
  logic       sel_CZN_src_ALU;
  logic       halted;

  modport master (
    input  ir, cond_met,
    output ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN, write_reg_en, mem_write,
           sel_PC_src_JUMP, sel_MEM_src_TR, sel_MEM_src_PC, sel_IR_3_2, sel_IR_4_3,
           sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1, sel_RF_write_src_ALU,
           sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU, halted
  );

  modport slave (
    output ir, cond_met,
    input  ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN, write_reg_en, mem_write,
           sel_PC_src_JUMP, sel_MEM_src_TR, sel_MEM_src_PC, sel_IR_3_2, sel_IR_4_3,
           sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1, sel_RF_write_src_ALU,
           sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_RF, sel_CZN_src_ALU, halted
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_instr_class_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_class_decoder
// Brief    : Classifies the opcode nibble ir[7:4] into an instruction class.
// Revision : 1.0 - initial release
// ============================================================================
module instr_class_decoder
  import cpu_ctrl_pkg::*;
(
  input  wire logic [3:0]   i_op,
  output logic              o_is_two_byte,
  output instr_class_t      o_iclass,
  output logic [1:0]        o_memop
);

  always_comb begin
    o_iclass = CLS_HALT;
    o_memop  = i_op[2:1];
    if (i_op[3] == OP_MEMREF) begin
      o_iclass = CLS_MEMREF;
    end else if (i_op[3:2] == OP_ALU) begin
      o_iclass = CLS_ALU;
    end else begin
      case (i_op)
        OP_MOV:  o_iclass = CLS_MOV;
        OP_ADDI: o_iclass = CLS_ADDI;
        OP_LDI:  o_iclass = CLS_LDI;
        default: o_iclass = CLS_HALT;
      endcase
    end
    o_is_two_byte = (o_iclass == CLS_MEMREF) || (o_iclass == CLS_ADDI) ||
                    (o_iclass == CLS_LDI);
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Multicycle Moore FSM sequencing the 8-bit / 13-bit-address datapath.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  control_unit_if.master   ctrl
);

  state_t       r_state;
  state_t       w_next;
  ctrl_t        w_ctrl;
  logic         w_is_two_byte;
  instr_class_t w_iclass;
  logic [1:0]   w_memop;

  instr_class_decoder u_decoder (
    .i_op          (ctrl.ir[7:4]),
    .o_is_two_byte (w_is_two_byte),
    .o_iclass      (w_iclass),
    .o_memop       (w_memop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = ctrl_default();
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_ctrl.ld_IR = 1'b1;
        w_ctrl.ld_DI = 1'b1;
        w_ctrl.ld_PC = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_two_byte)            w_next = S_FETCH2;
        else if (w_iclass == CLS_ALU) w_next = S_EXEC;
        else if (w_iclass == CLS_MOV) w_next = S_MOV;
        else                          w_next = S_HALT;
      end
      S_FETCH2: begin
        w_ctrl.ld_TR = 1'b1;
        w_ctrl.ld_PC = 1'b1;
        case (w_iclass)
          CLS_MEMREF: begin
            case (w_memop)
              MEM_LOAD:  w_next = S_MEM_RD;
              MEM_STORE: w_next = S_MEM_WR;
              default:   w_next = S_JUMP;
            endcase
          end
          CLS_ADDI: w_next = S_EXEC;
          default:  w_next = S_WB_TR;
        endcase
      end
      S_MEM_RD: begin
        w_ctrl.sel_MEM_src_TR = 1'b1;
        w_ctrl.sel_MEM_src_PC = 1'b0;
        w_ctrl.ld_TR          = 1'b1;
        w_next                = S_WB_TR;
      end
      S_MEM_WR: begin
        w_ctrl.sel_MEM_src_TR = 1'b1;
        w_ctrl.sel_MEM_src_PC = 1'b0;
        w_ctrl.sel_IR_4_3     = 1'b1;
        w_ctrl.sel_IR_3_2     = 1'b0;
        w_ctrl.mem_write      = 1'b1;
        w_next                = S_FETCH;
      end
      S_JUMP: begin
        // Untaken branch leaves PC already pointing past byte2
        w_ctrl.sel_PC_src_JUMP = 1'b1;
        w_ctrl.ld_PC           = (w_memop == MEM_JUMP) | ctrl.cond_met;
        w_next                 = S_FETCH;
      end
      S_EXEC: begin
        w_ctrl.ld_ALU = 1'b1;
        w_ctrl.ld_CZN = 1'b1;
        if (w_iclass == CLS_ADDI) begin
          w_ctrl.sel_ALU_src_TR   = 1'b1;
          w_ctrl.sel_ALU_src_reg1 = 1'b0;
        end
        w_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_ctrl.write_reg_en = 1'b1;
        w_next              = S_FETCH;
      end
      S_WB_TR: begin
        w_ctrl.sel_RF_write_src_TR_12_5 = 1'b1;
        w_ctrl.sel_RF_write_src_ALU     = 1'b0;
        w_ctrl.write_reg_en             = 1'b1;
        // LOAD names its register in DI[4:3]; LDI uses ir[3:2]
        if (w_iclass == CLS_MEMREF) begin
          w_ctrl.sel_IR_4_3 = 1'b1;
          w_ctrl.sel_IR_3_2 = 1'b0;
        end
        w_next = S_FETCH;
      end
      S_MOV: begin
        w_ctrl.sel_RF_write_src_reg1 = 1'b1;
        w_ctrl.sel_RF_write_src_ALU  = 1'b0;
        w_ctrl.write_reg_en          = 1'b1;
        w_ctrl.ld_CZN                = 1'b1;
        w_ctrl.sel_CZN_src_RF        = 1'b1;
        w_ctrl.sel_CZN_src_ALU       = 1'b0;
        w_next                       = S_FETCH;
      end
      S_HALT: w_ctrl.halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  assign ctrl.ld_PC                    = w_ctrl.ld_PC;
  assign ctrl.ld_IR                    = w_ctrl.ld_IR;
  assign ctrl.ld_DI                    = w_ctrl.ld_DI;
  assign ctrl.ld_TR                    = w_ctrl.ld_TR;
  assign ctrl.ld_ALU                   = w_ctrl.ld_ALU;
  assign ctrl.ld_CZN                   = w_ctrl.ld_CZN;
  assign ctrl.write_reg_en             = w_ctrl.write_reg_en;
  assign ctrl.mem_write                = w_ctrl.mem_write;
  assign ctrl.sel_PC_src_JUMP          = w_ctrl.sel_PC_src_JUMP;
  assign ctrl.sel_MEM_src_TR           = w_ctrl.sel_MEM_src_TR;
  assign ctrl.sel_MEM_src_PC           = w_ctrl.sel_MEM_src_PC;
  assign ctrl.sel_IR_3_2               = w_ctrl.sel_IR_3_2;
  assign ctrl.sel_IR_4_3               = w_ctrl.sel_IR_4_3;
  assign ctrl.sel_RF_write_src_TR_12_5 = w_ctrl.sel_RF_write_src_TR_12_5;
  assign ctrl.sel_RF_write_src_reg1    = w_ctrl.sel_RF_write_src_reg1;
  assign ctrl.sel_RF_write_src_ALU     = w_ctrl.sel_RF_write_src_ALU;
  assign ctrl.sel_ALU_src_reg1         = w_ctrl.sel_ALU_src_reg1;
  assign ctrl.sel_ALU_src_TR           = w_ctrl.sel_ALU_src_TR;
  assign ctrl.sel_CZN_src_RF           = w_ctrl.sel_CZN_src_RF;
  assign ctrl.sel_CZN_src_ALU          = w_ctrl.sel_CZN_src_ALU;
  assign ctrl.halted                   = w_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed per-cycle control-word checks for control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  // Control word bit masks, ld_PC in the MSB down to halted in the LSB
  localparam logic [20:0] c_LD_PC    = 21'd1 << 20;
  localparam logic [20:0] c_LD_IR    = 21'd1 << 19;
  localparam logic [20:0] c_LD_DI    = 21'd1 << 18;
  localparam logic [20:0] c_LD_TR    = 21'd1 << 17;
  localparam logic [20:0] c_LD_ALU   = 21'd1 << 16;
  localparam logic [20:0] c_LD_CZN   = 21'd1 << 15;
  localparam logic [20:0] c_WE       = 21'd1 << 14;
  localparam logic [20:0] c_MW       = 21'd1 << 13;
  localparam logic [20:0] c_PCJ      = 21'd1 << 12;
  localparam logic [20:0] c_MEM_TR   = 21'd1 << 11;
  localparam logic [20:0] c_MEM_PC   = 21'd1 << 10;
  localparam logic [20:0] c_IR32     = 21'd1 << 9;
  localparam logic [20:0] c_IR43     = 21'd1 << 8;
  localparam logic [20:0] c_RF_TR    = 21'd1 << 7;
  localparam logic [20:0] c_RF_REG1  = 21'd1 << 6;
  localparam logic [20:0] c_RF_ALU   = 21'd1 << 5;
  localparam logic [20:0] c_ALU_REG1 = 21'd1 << 4;
  localparam logic [20:0] c_ALU_TR   = 21'd1 << 3;
  localparam logic [20:0] c_CZN_RF   = 21'd1 << 2;
  localparam logic [20:0] c_CZN_ALU  = 21'd1 << 1;
  localparam logic [20:0] c_HALTED   = 21'd1;

  localparam logic [20:0] c_DEF       = c_MEM_PC | c_IR32 | c_RF_ALU | c_ALU_REG1 | c_CZN_ALU;
  localparam logic [20:0] c_V_IDLE    = c_DEF;
  localparam logic [20:0] c_V_FETCH   = c_DEF | c_LD_IR | c_LD_DI | c_LD_PC;
  localparam logic [20:0] c_V_DECODE  = c_DEF;
  localparam logic [20:0] c_V_FETCH2  = c_DEF | c_LD_TR | c_LD_PC;
  localparam logic [20:0] c_V_EXEC    = c_DEF | c_LD_ALU | c_LD_CZN;
  localparam logic [20:0] c_V_EXEC_I  = (c_DEF & ~c_ALU_REG1) | c_ALU_TR | c_LD_ALU | c_LD_CZN;
  localparam logic [20:0] c_V_WB_ALU  = c_DEF | c_WE;
  localparam logic [20:0] c_V_MEM_RD  = (c_DEF & ~c_MEM_PC) | c_MEM_TR | c_LD_TR;
  localparam logic [20:0] c_V_MEM_WR  = (c_DEF & ~c_MEM_PC & ~c_IR32) | c_MEM_TR | c_IR43 | c_MW;
  localparam logic [20:0] c_V_WB_LD   = (c_DEF & ~c_IR32 & ~c_RF_ALU) | c_IR43 | c_RF_TR | c_WE;
  localparam logic [20:0] c_V_WB_LDI  = (c_DEF & ~c_RF_ALU) | c_RF_TR | c_WE;
  localparam logic [20:0] c_V_JMP_NT  = c_DEF | c_PCJ;
  localparam logic [20:0] c_V_JMP_T   = c_DEF | c_PCJ | c_LD_PC;
  localparam logic [20:0] c_V_MOV     = (c_DEF & ~c_RF_ALU & ~c_CZN_ALU) | c_RF_REG1 | c_WE | c_LD_CZN | c_CZN_RF;
  localparam logic [20:0] c_V_HALT    = c_DEF | c_HALTED;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [20:0] exp_q[$];

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] obs();
    return {bus.ld_PC, bus.ld_IR, bus.ld_DI, bus.ld_TR, bus.ld_ALU, bus.ld_CZN,
            bus.write_reg_en, bus.mem_write, bus.sel_PC_src_JUMP,
            bus.sel_MEM_src_TR, bus.sel_MEM_src_PC, bus.sel_IR_3_2, bus.sel_IR_4_3,
            bus.sel_RF_write_src_TR_12_5, bus.sel_RF_write_src_reg1,
            bus.sel_RF_write_src_ALU, bus.sel_ALU_src_reg1, bus.sel_ALU_src_TR,
            bus.sel_CZN_src_RF, bus.sel_CZN_src_ALU, bus.halted};
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered while the DUT sits in FETCH; leaves it one cycle past the last entry
  task automatic run_seq(input string tag, input logic [7:0] op, input logic cm);
    bus.ir       = op;
    bus.cond_met = cm;
    foreach (exp_q[i]) begin
      check($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
      step();
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, obs(), c_V_IDLE);
    step();
    step();
    rst_n = 1'b1;
    check({tag, "_idle"}, obs(), c_V_IDLE);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.ir       = 8'h00;
    bus.cond_met = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) begin
      step();
      check("reset", obs(), c_V_IDLE);
    end
    rst_n = 1'b1;
    check("idle", obs(), c_V_IDLE);
    step();

    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_EXEC, c_V_WB_ALU};
    run_seq("alu86", 8'h86, 1'b0);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_MEM_RD, c_V_WB_LD};
    run_seq("load1A", 8'h1A, 1'b0);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_JMP_NT};
    run_seq("br60_nt", 8'h60, 1'b0);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_JMP_T};
    run_seq("br60_t", 8'h60, 1'b1);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_JMP_T};
    run_seq("jmp40", 8'h40, 1'b0);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_MEM_WR};
    run_seq("store25", 8'h25, 1'b1);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_EXEC_I, c_V_WB_ALU};
    run_seq("addiD4", 8'hD4, 1'b0);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_WB_LDI};
    run_seq("ldiE8", 8'hE8, 1'b0);
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_MOV};
    run_seq("movC6", 8'hC6, 1'b0);

    // Reset in the middle of an ALU instruction
    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_EXEC};
    run_seq("alu_pre", 8'h9B, 1'b0);
    async_reset("rst_exec");

    exp_q = '{c_V_FETCH, c_V_DECODE};
    run_seq("haltF0", 8'hF0, 1'b0);
    bus.cond_met = 1'b1;
    repeat (20) begin
      check("halt_hold", obs(), c_V_HALT);
      step();
    end
    async_reset("rst_halt");

    exp_q = '{c_V_FETCH, c_V_DECODE, c_V_FETCH2, c_V_WB_LDI};
    run_seq("ldi_after", 8'hE4, 1'b0);
    check("fetch_end", obs(), c_V_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
